// File: rtl/difftest_sim_ctrl_if.sv
// Handshake bundle between the difftest run controller (master) and SimTop / DPI step engine (slave).
// Optional SIM_CTRL_LOG_WINDOW_EN adds the log window inputs and log_enable output.
interface difftest_sim_ctrl_if #(
  parameter int TRAP_W = 32,
  parameter int CNT_W  = 64
);
  logic [CNT_W-1:0]  cfg_max_cycles;
  logic [CNT_W-1:0]  cfg_max_instrs;
  logic              sim_reset;
  logic              init_req;
  logic              init_ack;
  logic              difftest_step;
  logic [7:0]        commit_cnt;
  logic              step_req;
  logic              step_ack;
  logic [TRAP_W-1:0] step_trap;
  logic              perf_clean;
  logic              perf_dump;
  logic              finish;
  logic [TRAP_W-1:0] finish_code;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  instrs;
`ifdef SIM_CTRL_LOG_WINDOW_EN
  logic [CNT_W-1:0]  log_begin;
  logic [CNT_W-1:0]  log_end;
  logic              log_enable;

  modport master (
    input  cfg_max_cycles, cfg_max_instrs, init_ack, difftest_step, commit_cnt,
           step_ack, step_trap, log_begin, log_end,
    output sim_reset, init_req, step_req, perf_clean, perf_dump, finish,
           finish_code, cycles, instrs, log_enable
  );

  modport slave (
    output cfg_max_cycles, cfg_max_instrs, init_ack, difftest_step, commit_cnt,
           step_ack, step_trap, log_begin, log_end,
    input  sim_reset, init_req, step_req, perf_clean, perf_dump, finish,
           finish_code, cycles, instrs, log_enable
  );
`else
  modport master (
    input  cfg_max_cycles, cfg_max_instrs, init_ack, difftest_step, commit_cnt,
           step_ack, step_trap,
    output sim_reset, init_req, step_req, perf_clean, perf_dump, finish,
           finish_code, cycles, instrs
  );

  modport slave (
    output cfg_max_cycles, cfg_max_instrs, init_ack, difftest_step, commit_cnt,
           step_ack, step_trap,
    input  sim_reset, init_req, step_req, perf_clean, perf_dump, finish,
           finish_code, cycles, instrs
  );
`endif
endinterface

// File: rtl/difftest_sim_ctrl.sv
// Run-control FSM for difftest simulation: DUT reset, one-shot init, step handshakes, limits, perf dump, finish.
// Optional feature macro SIM_CTRL_LOG_WINDOW_EN enables the registered log_enable window output.
module difftest_sim_ctrl #(
  parameter int RESET_CYCLES = 100,
  parameter int DUMP_CYCLES  = 50,
  parameter int TRAP_W       = 32,
  parameter int CNT_W        = 64
) (
  input logic                 clock,
  input logic                 reset,
  difftest_sim_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_RST,
    S_INIT,
    S_RUN,
    S_WAIT,
    S_DUMP,
    S_DONE
  } state_t;

  localparam logic [TRAP_W-1:0] CODE_MAX_CYCLES = TRAP_W'(32'hFFFF_FFFE);
  localparam logic [TRAP_W-1:0] CODE_MAX_INSTRS = TRAP_W'(32'hFFFF_FFFD);
  localparam logic [31:0]       RESET_LAST      = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]       DUMP_LAST       = 32'(DUMP_CYCLES - 1);

  state_t           state;
  logic [31:0]      phase_cnt;
  logic [CNT_W-1:0] cycles_inc;
  logic [CNT_W-1:0] instrs_inc;
  logic             cyc_hit;
  logic             ins_hit;
  logic             trap_hit;
  logic             in_window;

  // Limits are judged on the post-increment counter values so the stop lands exactly on the limit.
  always_comb begin
    cycles_inc = bus.cycles + CNT_W'(1);
    instrs_inc = bus.instrs + CNT_W'(bus.commit_cnt);
    cyc_hit    = (bus.cfg_max_cycles != '0) && (cycles_inc >= bus.cfg_max_cycles);
    ins_hit    = (bus.cfg_max_instrs != '0) && (instrs_inc >= bus.cfg_max_instrs);
    trap_hit   = bus.step_ack && (bus.step_trap != '0);
`ifdef SIM_CTRL_LOG_WINDOW_EN
    in_window  = (bus.log_end > bus.log_begin) &&
                 (cycles_inc >= bus.log_begin) && (cycles_inc < bus.log_end);
`else
    in_window  = 1'b0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_RST;
      phase_cnt       <= '0;
      bus.sim_reset   <= 1'b1;
      bus.init_req    <= 1'b0;
      bus.step_req    <= 1'b0;
      bus.perf_clean  <= 1'b0;
      bus.perf_dump   <= 1'b0;
      bus.finish      <= 1'b0;
      bus.finish_code <= '0;
      bus.cycles      <= '0;
      bus.instrs      <= '0;
`ifdef SIM_CTRL_LOG_WINDOW_EN
      bus.log_enable  <= 1'b0;
`endif
    end else begin
      bus.perf_clean <= 1'b0;
      case (state)
        S_RST: begin
          if (phase_cnt == RESET_LAST) begin
            phase_cnt      <= '0;
            bus.sim_reset  <= 1'b0;
            bus.perf_clean <= 1'b1;
            bus.init_req   <= 1'b1;
            state          <= S_INIT;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        S_INIT: begin
          if (bus.init_ack) begin
            bus.init_req <= 1'b0;
            state        <= S_RUN;
          end
        end

        // Stop priority: trap reported by the step engine, then cycle limit, then instruction limit.
        S_RUN, S_WAIT: begin
          bus.cycles <= cycles_inc;
          bus.instrs <= instrs_inc;
`ifdef SIM_CTRL_LOG_WINDOW_EN
          bus.log_enable <= in_window;
`endif
          if ((state == S_WAIT) && trap_hit) begin
            bus.finish_code <= bus.step_trap;
            bus.step_req    <= 1'b0;
            bus.perf_dump   <= 1'b1;
            phase_cnt       <= '0;
            state           <= S_DUMP;
`ifdef SIM_CTRL_LOG_WINDOW_EN
            bus.log_enable  <= 1'b0;
`endif
          end else if (cyc_hit || ins_hit) begin
            bus.finish_code <= cyc_hit ? CODE_MAX_CYCLES : CODE_MAX_INSTRS;
            bus.step_req    <= 1'b0;
            bus.perf_dump   <= 1'b1;
            phase_cnt       <= '0;
            state           <= S_DUMP;
`ifdef SIM_CTRL_LOG_WINDOW_EN
            bus.log_enable  <= 1'b0;
`endif
          end else if (state == S_WAIT) begin
            if (bus.step_ack) begin
              bus.step_req <= 1'b0;
              state        <= S_RUN;
            end
          end else if (bus.difftest_step) begin
            bus.step_req <= 1'b1;
            state        <= S_WAIT;
          end
        end

        S_DUMP: begin
          if (phase_cnt == DUMP_LAST) begin
            bus.perf_dump <= 1'b0;
            bus.finish    <= 1'b1;
            state         <= S_DONE;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end

        S_DONE: begin
          state <= S_DONE;
        end

        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

`ifndef SIM_CTRL_LOG_WINDOW_EN
  logic unused_window;
  assign unused_window = in_window;
`endif

endmodule

// File: tb/tb_difftest_sim_ctrl.sv
// Self-checking bench for difftest_sim_ctrl: vector table, random steps vs reference model, corner sequences.
module tb_difftest_sim_ctrl;

  localparam int RESET_CYCLES = 100;
  localparam int DUMP_CYCLES  = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  difftest_sim_ctrl_if #(.TRAP_W(32), .CNT_W(64)) bus ();

  difftest_sim_ctrl #(
    .RESET_CYCLES(RESET_CYCLES),
    .DUMP_CYCLES (DUMP_CYCLES),
    .TRAP_W      (32),
    .CNT_W       (64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: simulation is active, waiting on a check, dumping for N more cycles, or done.
  logic [63:0] mCycles;
  logic [63:0] mInstrs;
  logic [31:0] mCode;
  bit          mActive;
  bit          mWaiting;
  bit          mDone;
  int          mDumpLeft;

  typedef struct {
    logic        step;
    logic        ack;
    logic [7:0]  commit;
    logic        expStepReq;
    logic [63:0] expCycles;
    logic [63:0] expInstrs;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mCycles   = '0;
    mInstrs   = '0;
    mCode     = '0;
    mActive   = 1'b0;
    mWaiting  = 1'b0;
    mDone     = 1'b0;
    mDumpLeft = 0;
  endfunction

  function automatic void modelStop(input logic [31:0] code);
    mActive   = 1'b0;
    mWaiting  = 1'b0;
    mDumpLeft = DUMP_CYCLES;
    mCode     = code;
  endfunction

  function automatic void modelEdge(input logic step, input logic ack, input logic [31:0] trap,
                                    input logic [7:0] commit);
    if (mActive) begin
      mCycles = mCycles + 64'd1;
      mInstrs = mInstrs + 64'(commit);
      if (mWaiting && ack && trap != 0)
        modelStop(trap);
      else if (bus.cfg_max_cycles != 0 && mCycles >= bus.cfg_max_cycles)
        modelStop(32'hFFFF_FFFE);
      else if (bus.cfg_max_instrs != 0 && mInstrs >= bus.cfg_max_instrs)
        modelStop(32'hFFFF_FFFD);
      else if (mWaiting)
        mWaiting = !ack;
      else
        mWaiting = step;
    end else if (mDumpLeft > 0) begin
      mDumpLeft--;
      if (mDumpLeft == 0) mDone = 1'b1;
    end
  endfunction

  task automatic applyStimulus(input logic step, input logic ack, input logic [31:0] trap,
                               input logic [7:0] commit);
    bus.difftest_step = step;
    bus.step_ack      = ack;
    bus.step_trap     = trap;
    bus.commit_cnt    = commit;
    modelEdge(step, ack, trap, commit);
    @(posedge clock);
    #1;
    bus.difftest_step = 1'b0;
    bus.step_ack      = 1'b0;
    bus.step_trap     = '0;
    bus.commit_cnt    = '0;
  endtask

  task automatic checkModel();
    checkOutput("step_req", 64'(bus.step_req), 64'(mWaiting));
    checkOutput("perf_dump", 64'(bus.perf_dump), 64'(mDumpLeft > 0));
    checkOutput("finish", 64'(bus.finish), 64'(mDone));
    checkOutput("finish_code", 64'(bus.finish_code), 64'(mCode));
    checkOutput("cycles", bus.cycles, mCycles);
    checkOutput("instrs", bus.instrs, mInstrs);
    checkOutput("init_req_quiet", 64'(bus.init_req), 64'd0);
    checkOutput("sim_reset_low", 64'(bus.sim_reset), 64'd0);
    checkOutput("perf_clean_quiet", 64'(bus.perf_clean), 64'd0);
  endtask

  task automatic stepCycle(input logic step, input logic ack, input logic [31:0] trap,
                           input logic [7:0] commit);
    applyStimulus(step, ack, trap, commit);
    checkModel();
  endtask

  task automatic randomCycle();
    logic s;
    logic a;
    s = ($urandom_range(0, 2) == 0);
    a = mWaiting && ($urandom_range(0, 1) == 1);
    stepCycle(s, a, 32'd0, 8'($urandom_range(0, 255)));
  endtask

  // Full reset release and init handshake; leaves the DUT freshly in the run phase.
  task automatic runResetInit(input int ackDelay);
    modelReset();
    reset             = 1'b1;
    bus.init_ack      = 1'b0;
    bus.difftest_step = 1'b0;
    bus.step_ack      = 1'b0;
    bus.step_trap     = '0;
    bus.commit_cnt    = '0;
    @(posedge clock);
    #1;
    checkOutput("rst_sim_reset", 64'(bus.sim_reset), 64'd1);
    checkOutput("rst_init_req", 64'(bus.init_req), 64'd0);
    checkOutput("rst_step_req", 64'(bus.step_req), 64'd0);
    checkOutput("rst_perf", 64'({bus.perf_clean, bus.perf_dump}), 64'd0);
    checkOutput("rst_finish", 64'(bus.finish), 64'd0);
    checkOutput("rst_finish_code", 64'(bus.finish_code), 64'd0);
    checkOutput("rst_cycles", bus.cycles, 64'd0);
    checkOutput("rst_instrs", bus.instrs, 64'd0);
    reset = 1'b0;
    for (int k = 1; k <= RESET_CYCLES; k++) begin
      @(posedge clock);
      #1;
      checkOutput("sim_reset_seq", 64'(bus.sim_reset), 64'(k < RESET_CYCLES));
      checkOutput("perf_clean_seq", 64'(bus.perf_clean), 64'(k == RESET_CYCLES));
      checkOutput("init_req_rise", 64'(bus.init_req), 64'(k == RESET_CYCLES));
    end
    for (int k = 1; k < ackDelay; k++) begin
      @(posedge clock);
      #1;
      checkOutput("init_req_hold", 64'(bus.init_req), 64'd1);
      checkOutput("perf_clean_once", 64'(bus.perf_clean), 64'd0);
    end
    bus.init_ack = 1'b1;
    @(posedge clock);
    #1;
    bus.init_ack = 1'b0;
    checkOutput("init_req_drop", 64'(bus.init_req), 64'd0);
    checkOutput("run_cycles_zero", bus.cycles, 64'd0);
    mActive = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dumpCount;
    int n;

    vecs[0]  = '{1'b1, 1'b0, 8'd2,   1'b1, 64'd1,  64'd2};
    vecs[1]  = '{1'b0, 1'b0, 8'd1,   1'b1, 64'd2,  64'd3};
    vecs[2]  = '{1'b0, 1'b1, 8'd0,   1'b0, 64'd3,  64'd3};
    vecs[3]  = '{1'b1, 1'b0, 8'd3,   1'b1, 64'd4,  64'd6};
    vecs[4]  = '{1'b1, 1'b0, 8'd0,   1'b1, 64'd5,  64'd6};
    vecs[5]  = '{1'b1, 1'b1, 8'd0,   1'b0, 64'd6,  64'd6};
    vecs[6]  = '{1'b0, 1'b0, 8'd255, 1'b0, 64'd7,  64'd261};
    vecs[7]  = '{1'b1, 1'b0, 8'd0,   1'b1, 64'd8,  64'd261};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,   1'b1, 64'd9,  64'd261};
    vecs[9]  = '{1'b0, 1'b1, 8'd0,   1'b0, 64'd10, 64'd261};
    vecs[10] = '{1'b0, 1'b0, 8'd0,   1'b0, 64'd11, 64'd261};

    bus.cfg_max_cycles = '0;
    bus.cfg_max_instrs = '0;
`ifdef SIM_CTRL_LOG_WINDOW_EN
    bus.log_begin = '0;
    bus.log_end   = '0;
`endif

    $display("[TB] reset, init with 5-cycle ack delay, step handshake table");
    runResetInit(5);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].step, vecs[i].ack, 32'd0, vecs[i].commit);
      checkOutput($sformatf("vec%0d_step_req", i), 64'(bus.step_req), 64'(vecs[i].expStepReq));
      checkOutput($sformatf("vec%0d_cycles", i), bus.cycles, vecs[i].expCycles);
      checkOutput($sformatf("vec%0d_instrs", i), bus.instrs, vecs[i].expInstrs);
      checkOutput($sformatf("vec%0d_idle", i), 64'({bus.perf_dump, bus.finish}), 64'd0);
    end

    $display("[TB] random steps against reference model");
    for (int i = 0; i < 200; i++) randomCycle();

    $display("[TB] checkpoint trap 0xff");
    if (!mWaiting) stepCycle(1'b1, 1'b0, 32'd0, 8'd1);
    stepCycle(1'b0, 1'b1, 32'h0000_00ff, 8'd4);
    checkOutput("trap_dump_latency", 64'(bus.perf_dump), 64'd1);
    checkOutput("trap_code", 64'(bus.finish_code), 64'h0000_00ff);
    dumpCount = 1;
    for (int i = 0; i < DUMP_CYCLES + 10; i++) begin
      stepCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), 8'($urandom_range(0, 255)));
      if (bus.perf_dump) dumpCount++;
    end
    checkOutput("dump_length", 64'(dumpCount), 64'(DUMP_CYCLES));
    checkOutput("trap_finish", 64'(bus.finish), 64'd1);
    checkOutput("trap_code_held", 64'(bus.finish_code), 64'h0000_00ff);

    $display("[TB] reset asserted while waiting on a check");
    runResetInit(5);
    stepCycle(1'b1, 1'b0, 32'd0, 8'd2);
    checkOutput("wait_step_req", 64'(bus.step_req), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_step_req", 64'(bus.step_req), 64'd0);
    checkOutput("async_sim_reset", 64'(bus.sim_reset), 64'd1);
    checkOutput("async_cycles", bus.cycles, 64'd0);
    runResetInit(5);
    stepCycle(1'b1, 1'b0, 32'd0, 8'd1);
    stepCycle(1'b0, 1'b0, 32'd0, 8'd1);
    stepCycle(1'b0, 1'b1, 32'd0, 8'd1);
    checkOutput("restart_instrs", bus.instrs, 64'd3);

    $display("[TB] cycle limit 1000");
    bus.cfg_max_cycles = 64'd1000;
    n = 0;
    while (!bus.finish && n < 1200) begin
      randomCycle();
      n++;
    end
    checkOutput("max_cycles_finish", 64'(bus.finish), 64'd1);
    checkOutput("max_cycles_code", 64'(bus.finish_code), 64'hFFFF_FFFE);
    checkOutput("max_cycles_frozen", bus.cycles, 64'd1000);

    $display("[TB] trap and cycle limit on the same edge");
    bus.cfg_max_cycles = 64'd20;
    runResetInit(1);
    for (int i = 0; i < 17; i++) stepCycle(1'b0, 1'b0, 32'd0, 8'd1);
    stepCycle(1'b1, 1'b0, 32'd0, 8'd1);
    stepCycle(1'b0, 1'b0, 32'd0, 8'd1);
    stepCycle(1'b0, 1'b1, 32'd5, 8'd1);
    checkOutput("prio_code", 64'(bus.finish_code), 64'd5);
    checkOutput("prio_cycles", bus.cycles, 64'd20);
    checkOutput("prio_step_req", 64'(bus.step_req), 64'd0);
    for (int i = 0; i < DUMP_CYCLES; i++) stepCycle(1'b0, 1'b0, 32'd0, 8'd0);
    checkOutput("prio_finish", 64'(bus.finish), 64'd1);

    $display("[TB] instruction limit 100");
    bus.cfg_max_cycles = '0;
    bus.cfg_max_instrs = 64'd100;
    runResetInit(2);
    for (int i = 0; i < 10; i++) stepCycle(1'b0, 1'b0, 32'd0, 8'd10);
    checkOutput("max_instrs_code", 64'(bus.finish_code), 64'hFFFF_FFFD);
    checkOutput("max_instrs_value", bus.instrs, 64'd100);
    checkOutput("max_instrs_dump", 64'(bus.perf_dump), 64'd1);

    $display("[TB] cycle limit beats instruction limit");
    bus.cfg_max_cycles = 64'd10;
    runResetInit(3);
    for (int i = 0; i < 10; i++) stepCycle(1'b0, 1'b0, 32'd0, 8'd10);
    checkOutput("both_limits_code", 64'(bus.finish_code), 64'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
